// File: rtl/trap_redirect_pkg.sv
// Shared types and helpers for the trap/redirect block of the FD/XB RV32I core.
// State encodings: RUN=2'd0, HANDLER=2'd1, HALT=2'd2.
package trap_redirect_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HANDLER = 2'd1,
        ST_HALT    = 2'd2
    } trap_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/trap_pc_sel.sv
// Priority next-PC selection: hold (frozen) > trap > mret > branch > stall > PC+4.
module trap_pc_sel
    import trap_redirect_pkg::*;
(
    input  logic        hold_all,
    input  logic        trap,
    input  logic        mret,
    input  logic        br,
    input  logic        stall,
    input  logic [31:0] cur_pc,
    input  logic [31:0] trap_vector,
    input  logic [31:0] mepc,
    input  logic [31:0] br_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    // Pick the next fetch address in strict priority order.
    always_comb begin
        next_pc = cur_pc;
        if (hold_all) begin
            next_pc = cur_pc;
        end else if (trap) begin
            next_pc = trap_vector;
        end else if (mret) begin
            next_pc = mepc;
        end else if (br) begin
            // Misaligned targets pass through; decode flags them next cycle.
            next_pc = br_target;
        end else if (stall) begin
            next_pc = cur_pc;
        end else begin
            next_pc = seq_pc(cur_pc);
        end
    end

    // A redirect is any control-flow change while fetch is not frozen.
    always_comb begin
        redirect = 1'b0;
        if (hold_all) begin
            redirect = 1'b0;
        end else begin
            redirect = trap | mret | br;
        end
    end

endmodule

// File: rtl/trap_redirect.sv
// PC owner and trap sequencer for the FD/XB RV32I core.
// Optional feature macro: TRAP_NEST_HALT_EN -- when defined, a trap taken
// while already in the handler halts the core instead of re-vectoring.
module trap_redirect
    import trap_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0100,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0000,
    parameter int          TRAP_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  XB_bubble,
    input  logic                  initiate_illinst,
    input  logic                  initiate_misaligned,
    input  logic                  XB_mret,
    input  logic                  XB_branch_taken,
    input  logic [31:0]           XB_branch_target,
    input  logic [31:0]           csr_mepc,
    output logic [31:0]           FD_pc,
    output logic                  FD_flush,
    output logic                  trap_taken,
    output logic                  in_handler,
    output logic                  halted,
    output logic [TRAP_CNT_W-1:0] trap_count
);

    trap_state_e           state_r;
    logic [31:0]           pc_r;
    logic [TRAP_CNT_W-1:0] count_r;
    logic                  in_handler_r;

    logic                  trap_s;
    logic                  mret_s;
    logic                  br_s;
    logic                  halt_s;
    logic                  nest_s;
    logic                  frozen_s;
    logic                  redirect_s;
    logic [31:0]           next_pc_s;

    // Event decode; trap requests arrive already bubble-gated.
    always_comb begin
        trap_s = initiate_illinst | initiate_misaligned;
        mret_s = XB_mret & ~XB_bubble;
        br_s   = XB_branch_taken & ~XB_bubble;
        halt_s = (state_r == ST_HALT);
`ifdef TRAP_NEST_HALT_EN
        nest_s = trap_s & (state_r == ST_HANDLER);
`else
        nest_s = 1'b0;
`endif
        // The nesting trap itself is not taken: fetch freezes from that cycle on.
        frozen_s = halt_s | nest_s;
    end

    trap_pc_sel u_pc_sel (
        .hold_all    (frozen_s),
        .trap        (trap_s),
        .mret        (mret_s),
        .br          (br_s),
        .stall       (stall),
        .cur_pc      (pc_r),
        .trap_vector (TRAP_VECTOR),
        .mepc        (csr_mepc),
        .br_target   (XB_branch_target),
        .next_pc     (next_pc_s),
        .redirect    (redirect_s)
    );

    // Fetch PC register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r <= RESET_VECTOR;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Saturating count of accepted traps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
        end else if (trap_taken && !(&count_r)) begin
            count_r <= count_r + {{(TRAP_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

`ifdef TRAP_NEST_HALT_EN
    logic halted_r;

    // Trap FSM with registered state flags; nested trap halts until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_RUN;
            in_handler_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (trap_s) begin
                        state_r      <= ST_HANDLER;
                        in_handler_r <= 1'b1;
                    end else begin
                        state_r      <= ST_RUN;
                        in_handler_r <= 1'b0;
                    end
                    halted_r <= 1'b0;
                end
                ST_HANDLER: begin
                    if (trap_s) begin
                        state_r      <= ST_HALT;
                        in_handler_r <= 1'b0;
                        halted_r     <= 1'b1;
                    end else if (mret_s) begin
                        state_r      <= ST_RUN;
                        in_handler_r <= 1'b0;
                        halted_r     <= 1'b0;
                    end else begin
                        state_r      <= ST_HANDLER;
                        in_handler_r <= 1'b1;
                        halted_r     <= 1'b0;
                    end
                end
                ST_HALT: begin
                    state_r      <= ST_HALT;
                    in_handler_r <= 1'b0;
                    halted_r     <= 1'b1;
                end
                default: begin
                    state_r      <= ST_RUN;
                    in_handler_r <= 1'b0;
                    halted_r     <= 1'b0;
                end
            endcase
        end
    end

    assign halted = halted_r;
`else
    // Trap FSM with registered state flag; nested trap re-vectors and stays in HANDLER.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_RUN;
            in_handler_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (trap_s) begin
                        state_r      <= ST_HANDLER;
                        in_handler_r <= 1'b1;
                    end else begin
                        state_r      <= ST_RUN;
                        in_handler_r <= 1'b0;
                    end
                end
                ST_HANDLER: begin
                    if (trap_s) begin
                        state_r      <= ST_HANDLER;
                        in_handler_r <= 1'b1;
                    end else if (mret_s) begin
                        state_r      <= ST_RUN;
                        in_handler_r <= 1'b0;
                    end else begin
                        state_r      <= ST_HANDLER;
                        in_handler_r <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_RUN;
                    in_handler_r <= 1'b0;
                end
            endcase
        end
    end

    assign halted = 1'b0;
`endif

    assign FD_pc      = pc_r;
    assign FD_flush   = redirect_s | frozen_s;
    assign trap_taken = trap_s & ~frozen_s;
    assign in_handler = in_handler_r;
    assign trap_count = count_r;

endmodule

// File: tb/tb_trap_redirect.sv
// Self-checking bench for trap_redirect (TRAP_CNT_W = 2 to reach saturation).
// Registered expectations are queued when a cycle is driven and popped after the edge.
module tb_trap_redirect;

    localparam int CW = 2;
    localparam logic [31:0] RV = 32'h0000_0100;
    localparam logic [31:0] TV = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          stall = 1'b0;
    logic          XB_bubble = 1'b0;
    logic          initiate_illinst = 1'b0;
    logic          initiate_misaligned = 1'b0;
    logic          XB_mret = 1'b0;
    logic          XB_branch_taken = 1'b0;
    logic [31:0]   XB_branch_target = 32'h0;
    logic [31:0]   csr_mepc = 32'h0;
    logic [31:0]   FD_pc;
    logic          FD_flush;
    logic          trap_taken;
    logic          in_handler;
    logic          halted;
    logic [CW-1:0] trap_count;

    trap_redirect #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV), .TRAP_CNT_W(CW)) dut (
        .clk                 (clk),
        .reset               (reset),
        .stall               (stall),
        .XB_bubble           (XB_bubble),
        .initiate_illinst    (initiate_illinst),
        .initiate_misaligned (initiate_misaligned),
        .XB_mret             (XB_mret),
        .XB_branch_taken     (XB_branch_taken),
        .XB_branch_target    (XB_branch_target),
        .csr_mepc            (csr_mepc),
        .FD_pc               (FD_pc),
        .FD_flush            (FD_flush),
        .trap_taken          (trap_taken),
        .in_handler          (in_handler),
        .halted              (halted),
        .trap_count          (trap_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]   pc;
        logic          inh;
        logic          hlt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int num_checks = 0;
    int num_fails  = 0;

    // Reference model state: 0 = RUN, 1 = HANDLER, 2 = HALT
    logic [31:0]   m_pc;
    int            m_state;
    logic [CW-1:0] m_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        num_checks++;
        if (obs !== expv) begin
            num_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_state = 0;
        m_cnt   = '0;
        exp_q.delete();
    endtask

    // Drive one cycle (called at posedge+1), check comb outputs, queue and check registered results.
    task automatic cyc(input logic ill, input logic mis, input logic mr, input logic bub,
                       input logic bt, input logic [31:0] tgt, input logic [31:0] mepc,
                       input logic stl);
        logic trap, mret, br, frozen, e_flush, e_taken;
        logic [31:0] npc;
        exp_t e, got;
        initiate_illinst    = ill;
        initiate_misaligned = mis;
        XB_mret             = mr;
        XB_bubble           = bub;
        XB_branch_taken     = bt;
        XB_branch_target    = tgt;
        csr_mepc            = mepc;
        stall               = stl;
        #1;
        trap = ill | mis;
        mret = mr & ~bub;
        br   = bt & ~bub;
`ifdef TRAP_NEST_HALT_EN
        frozen = (m_state == 2) || (m_state == 1 && trap);
`else
        frozen = 1'b0;
`endif
        if (frozen) begin
            e_flush = 1'b1;
            e_taken = 1'b0;
            npc     = m_pc;
        end else begin
            e_taken = trap;
            e_flush = trap | mret | br;
            if (trap)      npc = TV;
            else if (mret) npc = mepc;
            else if (br)   npc = tgt;
            else if (stl)  npc = m_pc;
            else           npc = m_pc + 32'd4;
        end
        check_val("FD_flush", {31'd0, FD_flush}, {31'd0, e_flush});
        check_val("trap_taken", {31'd0, trap_taken}, {31'd0, e_taken});
        if (e_taken && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (m_state == 2)            m_state = 2;
        else if (frozen)             m_state = 2;
        else if (trap)               m_state = 1;
        else if (mret)               m_state = 0;
        m_pc  = npc;
        e.pc  = m_pc;
        e.inh = (m_state == 1);
        e.hlt = (m_state == 2);
        e.cnt = m_cnt;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check_val("FD_pc", FD_pc, got.pc);
        check_val("in_handler", {31'd0, in_handler}, {31'd0, got.inh});
        check_val("halted", {31'd0, halted}, {31'd0, got.hlt});
        check_val("trap_count", {30'd0, trap_count}, {30'd0, got.cnt});
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_trap();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic do_mret(input logic [31:0] mepc, input logic bub);
        cyc(1'b0, 1'b0, 1'b1, bub, 1'b0, 32'h0, mepc, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        check_val("async_rst_pc", FD_pc, RV);
        check_val("async_rst_inh", {31'd0, in_handler}, 32'd0);
        check_val("async_rst_cnt", {30'd0, trap_count}, 32'd0);
        check_val("async_rst_halt", {31'd0, halted}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_pc", FD_pc, RV);
        check_val("rst_flush", {31'd0, FD_flush}, 32'd0);
        check_val("rst_cnt", {30'd0, trap_count}, 32'd0);
        reset = 1'b0;

        // Sequential fetch after reset
        idle();
        check_val("seq_104", FD_pc, 32'h104);
        idle();
        check_val("seq_108", FD_pc, 32'h108);

        // Illegal-instruction trap
        do_trap();
        check_val("trap_pc", FD_pc, 32'h0);
        check_val("trap_inh", {31'd0, in_handler}, 32'd1);
        check_val("trap_cnt", {30'd0, trap_count}, 32'd1);

        // Return from handler
        do_mret(32'h10C, 1'b0);
        check_val("mret_pc", FD_pc, 32'h10C);
        check_val("mret_inh", {31'd0, in_handler}, 32'd0);

        // Misaligned trap, then a bubbled MRET must not redirect
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_mret(32'h10C, 1'b1);
        check_val("bub_mret_pc", FD_pc, 32'h4);
        check_val("bub_mret_inh", {31'd0, in_handler}, 32'd1);
        do_mret(32'h200, 1'b0);

        // Trap + mret + branch with stall: trap wins
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 32'h300, 1'b1);
        check_val("simul_pc", FD_pc, 32'h0);
        check_val("simul_inh", {31'd0, in_handler}, 32'd1);
        do_mret(32'h200, 1'b0);

        // Branch (misaligned target passes), stall hold, MRET in RUN
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h402, 32'h0, 1'b0);
        check_val("br_pc", FD_pc, 32'h402);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        check_val("stall_pc", FD_pc, 32'h402);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h800, 32'h0, 1'b0);
        do_mret(32'h500, 1'b0);
        check_val("run_mret_pc", FD_pc, 32'h500);

        // Asynchronous reset mid-cycle
        async_reset();
        idle();
        check_val("post_rst_pc", FD_pc, 32'h104);

        // Nested trap
        do_trap();
        idle();
        do_trap();
`ifdef TRAP_NEST_HALT_EN
        check_val("nest_halted", {31'd0, halted}, 32'd1);
        check_val("nest_pc", FD_pc, 32'h4);
        check_val("nest_cnt", {30'd0, trap_count}, 32'd1);
        do_mret(32'h600, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h700, 32'h0, 1'b0);
        do_trap();
        check_val("halt_pc", FD_pc, 32'h4);
        check_val("halt_cnt", {30'd0, trap_count}, 32'd1);
        async_reset();
        check_val("halt_clr", {31'd0, halted}, 32'd0);
`else
        check_val("nest_pc", FD_pc, 32'h0);
        check_val("nest_cnt", {30'd0, trap_count}, 32'd2);
        check_val("nest_inh", {31'd0, in_handler}, 32'd1);
        check_val("nest_halted", {31'd0, halted}, 32'd0);
        async_reset();
`endif

        // Counter saturation: five traps, each followed by a return
        for (int i = 0; i < 5; i++) begin
            do_trap();
            do_mret(32'h100 + 32'(i * 16), 1'b0);
        end
        check_val("sat_cnt", {30'd0, trap_count}, 32'd3);

        // PC wrap at the top of the address space
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0, 1'b0);
        idle();
        check_val("wrap_pc", FD_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
